// File: rtl/ks_pipe_adder.sv
// ks_pipe_adder: pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Prefix levels are grouped PIPE_EVERY per stage; the sum XOR is formed after the final register.
module ks_pipe_adder #(
  parameter int WIDTH      = 16,
  parameter int PIPE_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] g_out
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NS     = 1 + (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             c0;

  // st_p/st_g/st_c0 ride along unchanged; st_gg/st_gp hold the prefix groups built so far.
  logic             st_v  [NS];
  logic             st_c0 [NS];
  logic [WIDTH-1:0] st_p  [NS];
  logic [WIDTH-1:0] st_g  [NS];
  logic [WIDTH-1:0] st_gg [NS];
  logic [WIDTH-1:0] st_gp [NS-1];

  // Combinational output of each prefix level; the last level needs no group propagate.
  logic [WIDTH-1:0] lvl_gg [1:LEVELS];
  logic [WIDTH-1:0] lvl_gp [1:LEVELS-1];

  logic [WIDTH-1:0] g_fin;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv | rst;

  assign b_eff = sub ? ~x2 : x2;
  assign c0    = sub ? ~cin : cin;
  assign p_in  = x1 ^ b_eff;
  // Carry-in folded into bit 0 so G[i-1:0] is directly the carry into bit i.
  assign g_in  = (x1 & b_eff) | {{(WIDTH-1){1'b0}}, p_in[0] & c0};

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are cleared along with the valids so every output reads 0 after reset.
      st_v[0]  <= 1'b0;
      st_c0[0] <= 1'b0;
      st_p[0]  <= '0;
      st_g[0]  <= '0;
      st_gg[0] <= '0;
      st_gp[0] <= '0;
    end else if (adv) begin
      st_v[0]  <= in_valid;
      st_c0[0] <= c0;
      st_p[0]  <= p_in;
      st_g[0]  <= g_in;
      st_gg[0] <= g_in;
      st_gp[0] <= p_in;
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int D = 1 << k;
    localparam logic [WIDTH-1:0] LOW_ONES = {WIDTH{1'b1}} >> (WIDTH - D);

    logic [WIDTH-1:0] src_g;
    logic [WIDTH-1:0] src_p;

    if (k % PIPE_EVERY == 0) begin : g_from_reg
      assign src_g = st_gg[k / PIPE_EVERY];
      assign src_p = st_gp[k / PIPE_EVERY];
    end else begin : g_from_comb
      assign src_g = lvl_gg[k];
      assign src_p = lvl_gp[k];
    end

    // Shifting in zeros (G) and ones (P) makes nodes below D pass through untouched.
    assign lvl_gg[k+1] = src_g | (src_p & (src_g << D));

    if (k + 1 < LEVELS) begin : g_prop
      assign lvl_gp[k+1] = src_p & ((src_p << D) | LOW_ONES);
    end
  end

  for (genvar j = 1; j < NS; j++) begin : g_stage
    localparam int LV_DONE = (j * PIPE_EVERY < LEVELS) ? j * PIPE_EVERY : LEVELS;

    always_ff @(posedge clk) begin
      if (rst) begin
        st_v[j]  <= 1'b0;
        st_c0[j] <= 1'b0;
        st_p[j]  <= '0;
        st_g[j]  <= '0;
        st_gg[j] <= '0;
      end else if (adv) begin
        st_v[j]  <= st_v[j-1];
        st_c0[j] <= st_c0[j-1];
        st_p[j]  <= st_p[j-1];
        st_g[j]  <= st_g[j-1];
        st_gg[j] <= lvl_gg[LV_DONE];
      end
    end

    if (j < NS - 1) begin : g_gp_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          st_gp[j] <= '0;
        end else if (adv) begin
          st_gp[j] <= lvl_gp[LV_DONE];
        end
      end
    end
  end

  assign g_fin     = st_gg[NS-1];
  assign out_valid = st_v[NS-1];
  assign s         = st_p[NS-1] ^ {g_fin[WIDTH-2:0], st_c0[NS-1]};
  assign cout      = g_fin[WIDTH-1];
  assign ovf       = g_fin[WIDTH-1] ^ g_fin[WIDTH-2];
  assign p_out     = st_p[NS-1];
  assign g_out     = st_g[NS-1];

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Self-checking bench for ks_pipe_adder: directed corners, streaming with back-pressure,
// reset mid-flight, and a WIDTH x PIPE_EVERY sweep against an arithmetic reference.
module tb_ks_pipe_adder;
  localparam int W    = 16;
  localparam int NS16 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] x1, x2, s, p_out, g_out;

  int n_checks = 0;
  int n_errors = 0;

  ks_pipe_adder #(.WIDTH(W), .PIPE_EVERY(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .p_out(p_out), .g_out(g_out)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic [15:0] p;
    logic [15:0] g;
  } res_t;

  // Reference: plain integer arithmetic on the effective operands.
  function automatic res_t model16(input logic [15:0] a, input logic [15:0] bx,
                                   input logic ci, input logic sb);
    res_t        r;
    logic [15:0] b;
    logic        c;
    logic [16:0] sum;
    int          sv;
    b      = sb ? ~bx : bx;
    c      = sb ? ~ci : ci;
    sum    = {1'b0, a} + {1'b0, b} + {16'd0, c};
    sv     = int'($signed(a)) + int'($signed(b)) + int'(c);
    r.s    = sum[15:0];
    r.cout = sum[16];
    r.ovf  = (sv > 32767) || (sv < -32768);
    r.p    = a ^ b;
    r.g    = a & b;
    if (r.p[0] && c) r.g[0] = 1'b1;
    return r;
  endfunction

  // Directed vectors with hand-derived sum/cout/ovf.
  logic [15:0] dir_a  [6] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0005, 16'h0000};
  logic [15:0] dir_b  [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0007, 16'h0000};
  logic        dir_ci [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        dir_sb [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] dir_s  [6] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'hFFFD, 16'h0001};
  logic        dir_co [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        dir_ov [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic test_reset();
    bit seen;
    rst = 1'b1; in_valid = 1'b1; x1 = 16'h1234; x2 = 16'h4321; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    n_checks++;
    if ({out_valid, s, cout, ovf, p_out, g_out} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got v=%b s=%h co=%b ov=%b p=%h g=%h exp all 0",
               out_valid, s, cout, ovf, p_out, g_out);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < NS16 + 2; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen) begin
      n_errors++; $display("FAIL reset_ignores_in_valid got out_valid=1 exp=0");
    end
  endtask

  task automatic test_directed();
    res_t exp;
    int   lat;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x1 = dir_a[i]; x2 = dir_b[i]; cin = dir_ci[i]; sub = dir_sb[i];
      in_valid = 1'b1;
      exp = model16(x1, x2, cin, sub);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
        @(posedge clk); lat++; @(negedge clk);
      end
      n_checks++;
      if (lat != NS16 || out_valid !== 1'b1) begin
        n_errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NS16);
      end
      n_checks++;
      if ({s, cout, ovf} !== {dir_s[i], dir_co[i], dir_ov[i]}) begin
        n_errors++;
        $display("FAIL dir%0d_result got s=%h co=%b ov=%b exp s=%h co=%b ov=%b",
                 i, s, cout, ovf, dir_s[i], dir_co[i], dir_ov[i]);
      end
      n_checks++;
      if ({p_out, g_out} !== {exp.p, exp.g}) begin
        n_errors++;
        $display("FAIL dir%0d_pg got p=%h g=%h exp p=%h g=%h", i, p_out, g_out, exp.p, exp.g);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    res_t exp;
    res_t held;
    bit   stalled, acc;
    int   sent, got, cyc;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0;
    x1 = 16'($urandom); x2 = 16'($urandom);
    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    while (got < 20 && cyc < 300) begin
      out_ready = (cyc % 3 == 0);
      @(negedge clk);
      n_checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_errors++;
        $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, !out_valid || out_ready);
      end
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || {s, cout, ovf, p_out, g_out} !== held) begin
          n_errors++;
          $display("FAIL b2b_stall_hold cyc=%0d got v=%b r=%h exp v=1 r=%h",
                   cyc, out_valid, {s, cout, ovf, p_out, g_out}, held);
        end
      end
      stalled = out_valid && !out_ready;
      held    = {s, cout, ovf, p_out, g_out};
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++; $display("FAIL b2b_extra_beat got unexpected result exp none");
        end else begin
          exp = q.pop_front();
          if ({s, cout, ovf, p_out, g_out} !== exp) begin
            n_errors++;
            $display("FAIL b2b_beat%0d got s=%h co=%b ov=%b p=%h g=%h exp s=%h co=%b ov=%b p=%h g=%h",
                     got, s, cout, ovf, p_out, g_out, exp.s, exp.cout, exp.ovf, exp.p, exp.g);
          end
        end
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back(model16(x1, x2, cin, sub));
        sent++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (sent < 20) begin
          x1 = 16'($urandom); x2 = 16'($urandom);
          cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      cyc++;
    end
    n_checks++;
    if (got != 20 || q.size() != 0) begin
      n_errors++; $display("FAIL b2b_count got=%0d exp=20 (left %0d)", got, q.size());
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    res_t exp;
    int   lat;
    bit   seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x1 = 16'($urandom); x2 = 16'($urandom);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst = 1'b1; x1 = 16'hAAAA;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, s, cout, ovf, p_out, g_out} !== '0) begin
      n_errors++;
      $display("FAIL mid_rst_outputs got v=%b s=%h co=%b ov=%b p=%h g=%h exp all 0",
               out_valid, s, cout, ovf, p_out, g_out);
    end
    seen = 1'b0;
    for (int i = 0; i < NS16 + 2; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_errors++; $display("FAIL mid_rst_flushed got out_valid=1 exp=0");
    end
    @(posedge clk); #1;
    x1 = 16'h1357; x2 = 16'h2468; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    exp = model16(x1, x2, cin, sub);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    n_checks++;
    if (lat != NS16 || {s, cout, ovf, p_out, g_out} !== exp) begin
      n_errors++;
      $display("FAIL mid_rst_next_beat got lat=%0d r=%h exp lat=%0d r=%h",
               lat, {s, cout, ovf, p_out, g_out}, NS16, exp);
    end
    @(posedge clk); #1;
  endtask

  // Parameter sweep: one DUT per (WIDTH, PIPE_EVERY), each run by its own process.
  logic sweep_go = 1'b0;
  bit   sweep_done [12];

  for (genvar wi = 0; wi < 4; wi++) begin : g_sw_w
    for (genvar pi = 0; pi < 3; pi++) begin : g_sw_p
      localparam int SW  = (wi == 0) ? 4 : (wi == 1) ? 8 : (wi == 2) ? 32 : 64;
      localparam int LV  = $clog2(SW);
      localparam int PE  = (pi == 0) ? 1 : (pi == 1) ? 2 : LV;
      localparam int NSX = 1 + (LV + PE - 1) / PE;
      localparam int IDX = wi * 3 + pi;

      logic          rst_s = 1'b1, iv = 1'b0, ir, ci = 1'b0, sb = 1'b0, ov, rdy = 1'b1, co, of;
      logic [SW-1:0] a = '0, bx = '0, sum, pp, gg;

      ks_pipe_adder #(.WIDTH(SW), .PIPE_EVERY(PE)) u_dut (
        .clk(clk), .rst(rst_s), .in_valid(iv), .in_ready(ir),
        .x1(a), .x2(bx), .cin(ci), .sub(sb),
        .out_valid(ov), .out_ready(rdy),
        .s(sum), .cout(co), .ovf(of), .p_out(pp), .g_out(gg)
      );

      initial begin : sweep_run
        logic [3*SW+1:0] q_res [$];
        logic [3*SW+1:0] e_res;
        logic [SW:0]     e_sum;
        logic [SW-1:0]   b_e, e_g;
        logic [63:0]     r64;
        logic            c_e, e_ovf;
        bit              acc;
        int              lat, sent, got, cyc;
        wait (sweep_go);
        @(posedge clk); #1;
        rst_s = 1'b0;
        for (int c = 0; c < 2; c++) begin
          a  = (c == 0) ? '1 : '0;
          bx = (c == 0) ? {{(SW-1){1'b0}}, 1'b1} : '0;
          ci = (c == 1); sb = 1'b0; iv = 1'b1; rdy = 1'b1;
          e_sum = {1'b0, a} + {1'b0, bx} + {{SW{1'b0}}, ci};
          @(posedge clk); #1;
          iv = 1'b0;
          lat = 1;
          @(negedge clk);
          while (!ov && lat < 4 * NSX + 4) begin
            @(posedge clk); lat++; @(negedge clk);
          end
          n_checks++;
          if (lat != NSX || ov !== 1'b1) begin
            n_errors++; $display("FAIL sweep_w%0d_pe%0d_latency got=%0d exp=%0d", SW, PE, lat, NSX);
          end
          n_checks++;
          if ({co, sum} !== e_sum) begin
            n_errors++;
            $display("FAIL sweep_w%0d_pe%0d_corner%0d got=%h exp=%h", SW, PE, c, {co, sum}, e_sum);
          end
          @(posedge clk); #1;
        end
        sent = 0; got = 0; cyc = 0;
        while ((sent < 1000 || got < sent) && cyc < 8000) begin
          if (!iv && sent < 1000 && $urandom_range(0, 7) != 0) begin
            r64 = {$urandom, $urandom}; a  = r64[SW-1:0];
            r64 = {$urandom, $urandom}; bx = r64[SW-1:0];
            ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
            iv = 1'b1;
          end
          rdy = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (ov && rdy) begin
            n_checks++;
            if (q_res.size() == 0) begin
              n_errors++; $display("FAIL sweep_w%0d_pe%0d_extra got unexpected beat exp none", SW, PE);
            end else begin
              e_res = q_res.pop_front();
              if ({co, sum, of, pp, gg} !== e_res) begin
                n_errors++;
                $display("FAIL sweep_w%0d_pe%0d_beat%0d got=%h exp=%h", SW, PE, got,
                         {co, sum, of, pp, gg}, e_res);
              end
            end
            got++;
          end
          acc = iv && ir;
          if (acc) begin
            b_e   = sb ? ~bx : bx;
            c_e   = sb ? ~ci : ci;
            e_sum = {1'b0, a} + {1'b0, b_e} + {{SW{1'b0}}, c_e};
            e_ovf = (a[SW-1] == b_e[SW-1]) && (e_sum[SW-1] != a[SW-1]);
            e_g   = a & b_e;
            if ((a[0] ^ b_e[0]) && c_e) e_g[0] = 1'b1;
            q_res.push_back({e_sum, e_ovf, a ^ b_e, e_g});
            sent++;
          end
          @(posedge clk); #1;
          if (acc) iv = 1'b0;
          cyc++;
        end
        n_checks++;
        if (got != 1000 || q_res.size() != 0) begin
          n_errors++;
          $display("FAIL sweep_w%0d_pe%0d_count got=%0d exp=1000 (left %0d)", SW, PE, got, q_res.size());
        end
        sweep_done[IDX] = 1'b1;
      end
    end
  end

  task automatic test_param_sweep();
    int cyc;
    int ndone;
    cyc = 0;
    sweep_go = 1'b1;
    do begin
      @(posedge clk);
      cyc++;
      ndone = 0;
      foreach (sweep_done[i]) ndone += int'(sweep_done[i]);
    end while (ndone < 12 && cyc < 20000);
    n_checks++;
    if (ndone != 12) begin
      n_errors++; $display("FAIL sweep_timeout got=%0d done exp=12", ndone);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; x1 = '0; x2 = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ks_pipe_adder.md
Name: ks_pipe_adder

Overview:
Parametrised, pipelined Kogge-Stone prefix adder/subtractor. It is the next generation of the fixed 4-bit combinational KS adder: generic width, configurable register insertion between prefix levels, an add/sub mode, and signed overflow. It streams operands through a valid/ready pipeline and sits in datapaths that need a high-frequency wide adder with back-pressure.

Parameters:
WIDTH, 16, operand width; power of two, at least 4; LEVELS = log2(WIDTH) prefix levels.
PIPE_EVERY, 1, pipeline register inserted after every PIPE_EVERY prefix levels; legal range 1..LEVELS.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  adder can accept a beat this cycle
x1  in  WIDTH  operand A
x2  in  WIDTH  operand B
cin  in  1  carry-in (add) / borrow-in (sub)
sub  in  1  0 = A+B+cin; 1 = A-B-cin
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
s  out  WIDTH  sum/difference
cout  out  1  carry-out (sub: 1 = no borrow)
ovf  out  1  signed two's-complement overflow
p_out  out  WIDTH  bitwise propagate of the effective operands, aligned with s
g_out  out  WIDTH  bitwise generate, aligned with s; bit 0 folds in the effective carry-in

Behaviour:
- Effective operands: b = sub ? ~x2 : x2; c0 = sub ? ~cin : cin. p = x1^b; g = x1&b; g[0] = (x1[0]&b[0]) | (p[0]&c0).
- Prefix: standard Kogge-Stone. Level k (k = 0..LEVELS-1) combines node i with node i-2^k for i >= 2^k; nodes with i < 2^k pass through. After LEVELS levels, carry into bit i = G[i-1:0] for i >= 1 and c0 for i = 0.
- Outputs: s[i] = p[i]^carry_i. cout = G[WIDTH-1:0]. ovf = carry_into_msb ^ cout.
- Results must equal (x1 + b + c0) mod 2^(WIDTH+1) for all inputs, with cout as bit WIDTH.
- Pipeline: stage 0 registers p, g, x1/b MSBs and c0. A register follows every PIPE_EVERY levels. The final register also follows the last level, even if LEVELS is not a multiple of PIPE_EVERY. Sum XOR, cout and ovf are formed combinationally from the final register.
- Stage count NS = 1 + ceil(LEVELS/PIPE_EVERY). Latency from an accepted input to out_valid is NS cycles when there is no stall.
- Every stage carries a valid bit. p and c0 are carried alongside through all stages.
- Flow control is a global stall: adv = ~out_valid | out_ready.
  - in_ready = adv, combinational and not dependent on in_valid.
  - When adv=1, all stages shift by one and stage 0 loads (in_valid, operands).
  - When adv=0, all stage registers and valids hold, and s/cout/ovf/p_out/g_out stay stable.
- A bubble (in_valid=0 while adv=1) propagates as valid=0. Data registers of invalid stages may hold anything, but outputs are don't-care only while out_valid=0.
- Throughput: one result per cycle under continuous in_valid and out_ready.
- Reset: every stage valid clears to 0 on the same edge; out_valid=0 the cycle after rst. Data registers also reset to 0, so s=0, cout=0, ovf=0, p_out=0, g_out=0. in_ready=1 while rst is asserted and after. Any in-flight beats are discarded, and in_valid is ignored during rst.
- Simultaneous accept and emit in one cycle is legal and required. It loses no beat and duplicates no beat.

Test Plan:
- WIDTH=16, PIPE_EVERY=1 (NS=5): x1=0xFFFF, x2=0x0001, cin=0, sub=0 -> after exactly 5 cycles s=0x0000, cout=1, ovf=0, p_out=0xFFFE, g_out=0x0001.
- Signed overflow: x1=0x7FFF, x2=0x0001, sub=0 -> s=0x8000, cout=0, ovf=1. Also x1=0x8000, x2=0x0001, sub=1, cin=0 -> s=0x7FFF, cout=1, ovf=1.
- Subtract with borrow: x1=0x0005, x2=0x0007, sub=1, cin=0 -> s=0xFFFE, cout=0. Same with cin=1 -> s=0xFFFD, cout=0.
- Streaming and back-pressure: issue 20 random beats back-to-back with out_ready toggling 1,0,0,1,... Required: in_ready tracks adv, outputs are stable during stalls, all 20 results arrive in order, and each matches the reference model.
- Parameter sweep: WIDTH in {4, 8, 32, 64} × PIPE_EVERY in {1, 2, LEVELS}. Check latency = NS, and run 1000 random beats plus carry-chain corners (all-ones + 1, 0 + 0 with cin=1) against a golden A+B model.
- Reset mid-flight: assert rst for 1 cycle with 3 beats in the pipe -> no out_valid appears afterwards for those beats, all outputs read 0, and the next accepted beat emerges NS cycles later with the correct result.
